// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and shift helper for the registered EX-stage ALU.
// Optional iterative multiplier is enabled by defining SEQ_ALU_MUL_EN.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // True when a shift amount pushes every operand bit out of the word.
    function automatic logic shift_saturates(input logic [63:0] amount, input int width);
        return amount >= 64'(width);
    endfunction

endpackage

// File: rtl/seq_alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low half of the product.
// Only instantiated when SEQ_ALU_MUL_EN is defined.
module seq_alu_mul_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] acc_step;

    // The final step's sum is exposed combinationally so the parent can load it on the same edge.
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = busy_q && (cnt_q == LAST_STEP);
        product  = acc_step;
    end

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = multiplicand;
            mplier_d = multiplier;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (done) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked, registered EX-stage ALU with flags and signed compares/shifts.
// Define SEQ_ALU_MUL_EN to make opcode 10 an iterative multiply; otherwise it returns operandA.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ALU_CON_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [DATA_WIDTH-1:0]    operandA,
    input  logic [DATA_WIDTH-1:0]    operandB,
    input  logic [ALU_CON_WIDTH-1:0] aluCon,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     zero,
    output logic                     overflow
);

    localparam int MSB = DATA_WIDTH - 1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  overflow_q, overflow_d;

    logic                  accept;
    logic                  is_mul;
    logic                  mul_start;
    logic                  mul_done;
    logic [DATA_WIDTH-1:0] mul_product;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic                  shift_sat;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ovf;

    assign sum       = operandA + operandB;
    assign diff      = operandA - operandB;
    assign shift_sat = shift_saturates(64'(operandB), DATA_WIDTH);

    always_comb begin
        alu_res = operandA;
        alu_ovf = 1'b0;
        case (aluCon)
            ALU_CON_WIDTH'(OP_ADD): begin
                alu_res = sum;
                alu_ovf = (operandA[MSB] == operandB[MSB]) && (sum[MSB] != operandA[MSB]);
            end
            ALU_CON_WIDTH'(OP_SUB): begin
                alu_res = diff;
                alu_ovf = (operandA[MSB] != operandB[MSB]) && (diff[MSB] != operandA[MSB]);
            end
            ALU_CON_WIDTH'(OP_AND):  alu_res = operandA & operandB;
            ALU_CON_WIDTH'(OP_OR):   alu_res = operandA | operandB;
            ALU_CON_WIDTH'(OP_XOR):  alu_res = operandA ^ operandB;
            ALU_CON_WIDTH'(OP_SLL):  alu_res = shift_sat ? '0 : (operandA << operandB);
            ALU_CON_WIDTH'(OP_SRL):  alu_res = shift_sat ? '0 : (operandA >> operandB);
            ALU_CON_WIDTH'(OP_SRA):
                alu_res = shift_sat ? {DATA_WIDTH{operandA[MSB]}}
                                    : DATA_WIDTH'($signed(operandA) >>> operandB);
            ALU_CON_WIDTH'(OP_SLT):  alu_res = DATA_WIDTH'($signed(operandA) < $signed(operandB));
            ALU_CON_WIDTH'(OP_SLTU): alu_res = DATA_WIDTH'(operandA < operandB);
            default:                 alu_res = operandA;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    assign is_mul = (aluCon == ALU_CON_WIDTH'(OP_MUL));

    seq_alu_mul_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .start       (mul_start),
        .multiplicand(operandA),
        .multiplier  (operandB),
        .done        (mul_done),
        .product     (mul_product)
    );
`else
    assign is_mul      = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    assign accept    = inValid && inReady;
    assign mul_start = accept && is_mul;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE releases on outReady and may immediately take the next op, giving back-to-back issue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? ST_MUL_RUN : ST_DONE;
                end
            end
            ST_MUL_RUN: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (outReady) begin
                    if (accept) begin
                        state_d = is_mul ? ST_MUL_RUN : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inReady  = 1'b0;
        outValid = 1'b0;
        case (state_q)
            ST_IDLE: inReady = 1'b1;
            ST_DONE: begin
                outValid = 1'b1;
                inReady  = outReady;
            end
            default: begin
                inReady  = 1'b0;
                outValid = 1'b0;
            end
        endcase
    end

    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        if (accept && !is_mul) begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            overflow_d = alu_ovf;
        end else if ((state_q == ST_MUL_RUN) && mul_done) begin
            result_d   = mul_product;
            zero_d     = (mul_product == '0);
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at DATA_WIDTH=16.
// Exercises the multiplier path when SEQ_ALU_MUL_EN is defined, the opcode-10 passthrough otherwise.
module tb_seq_alu;

    localparam int DW = 16;
    localparam int CW = 4;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_AND  = 4'd2;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_SLL  = 4'd5;
    localparam logic [3:0] C_SRL  = 4'd6;
    localparam logic [3:0] C_SRA  = 4'd7;
    localparam logic [3:0] C_SLT  = 4'd8;
    localparam logic [3:0] C_SLTU = 4'd9;
    localparam logic [3:0] C_MUL  = 4'd10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [DW-1:0] operandA = '0;
    logic [DW-1:0] operandB = '0;
    logic [CW-1:0] aluCon = '0;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [DW-1:0] result;
    logic          zero;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    seq_alu #(
        .DATA_WIDTH(DW),
        .ALU_CON_WIDTH(CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inValid (inValid),
        .inReady (inReady),
        .operandA(operandA),
        .operandB(operandB),
        .aluCon  (aluCon),
        .outValid(outValid),
        .outReady(outReady),
        .result  (result),
        .zero    (zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [CW-1:0] con, input logic rdy);
        inValid  = v;
        operandA = a;
        operandB = b;
        aluCon   = con;
        outReady = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [DW-1:0] res, input logic z, input logic ovf);
        checkOutput({tag, ".outValid"}, 32'(outValid), 32'd1);
        checkOutput({tag, ".result"}, 32'(result), 32'(res));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(z));
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] seq_alu directed test start");
        applyStimulus(1'b0, '0, '0, C_ADD, 1'b0);
        stepClock();
        stepClock();
        checkOutput("reset.outValid", 32'(outValid), 32'd0);
        checkOutput("reset.inReady", 32'(inReady), 32'd1);
        checkOutput("reset.result", 32'(result), 32'h0);
        checkOutput("reset.zero", 32'(zero), 32'd0);
        checkOutput("reset.overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Back-to-back single-cycle ops with outReady held high.
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, C_ADD, 1'b1);
        stepClock();
        checkResult("add_ovf", 16'h8000, 1'b0, 1'b1);
        checkOutput("add_ovf.inReady", 32'(inReady), 32'd1);
        applyStimulus(1'b1, 16'h0005, 16'h0005, C_SUB, 1'b1);
        stepClock();
        checkResult("sub_zero", 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h8000, 16'h0004, C_SRA, 1'b1);
        stepClock();
        checkResult("sra4", 16'hF800, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 16'h0010, C_SLL, 1'b1);
        stepClock();
        checkResult("sll16", 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h8001, 16'h0014, C_SRA, 1'b1);
        stepClock();
        checkResult("sra20", 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, C_SLT, 1'b1);
        stepClock();
        checkResult("slt", 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, C_SLTU, 1'b1);
        stepClock();
        checkResult("sltu", 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'hF000, 16'h0004, C_SRL, 1'b1);
        stepClock();
        checkResult("srl4", 16'h0F00, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hF0F0, 16'hFF00, C_AND, 1'b1);
        stepClock();
        checkResult("and", 16'hF000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hF0F0, 16'hFF00, C_OR, 1'b1);
        stepClock();
        checkResult("or", 16'hFFF0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h8000, 16'h0001, C_SUB, 1'b1);
        stepClock();
        checkResult("sub_ovf", 16'h7FFF, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h1234, 16'h5678, 4'd15, 1'b1);
        stepClock();
        checkResult("op15_passA", 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, C_ADD, 1'b1);
        stepClock();
        checkOutput("idle.outValid", 32'(outValid), 32'd0);
        checkOutput("idle.inReady", 32'(inReady), 32'd1);

        // Consumer stall: result frozen and upstream blocked, then release takes the pending op.
        applyStimulus(1'b1, 16'h0010, 16'h0020, C_ADD, 1'b0);
        stepClock();
        checkResult("stall_first", 16'h0030, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 16'h0F0F, C_XOR, 1'b0);
        for (int i = 0; i < 5; i++) begin
            stepClock();
            checkResult("stall_hold", 16'h0030, 1'b0, 1'b0);
            checkOutput("stall_hold.inReady", 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        #1;
        checkOutput("stall_release.inReady", 32'(inReady), 32'd1);
        stepClock();
        checkResult("stall_pending_xor", 16'h0FF0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, C_ADD, 1'b1);
        stepClock();
        checkOutput("stall_idle.outValid", 32'(outValid), 32'd0);

`ifdef SEQ_ALU_MUL_EN
        applyStimulus(1'b1, 16'h0123, 16'h0011, C_MUL, 1'b1);
        stepClock();
        applyStimulus(1'b1, 16'h0001, 16'h0001, C_ADD, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("mul_run.inReady", 32'(inReady), 32'd0);
            checkOutput("mul_run.outValid", 32'(outValid), 32'd0);
            stepClock();
        end
        checkResult("mul_done", 16'h1353, 1'b0, 1'b0);
        checkOutput("mul_done.inReady", 32'(inReady), 32'd1);
        stepClock();
        checkResult("add_after_mul", 16'h0002, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, C_ADD, 1'b1);
        stepClock();
        checkOutput("mul_idle.outValid", 32'(outValid), 32'd0);

        // Reset lands in the middle of a multiply.
        applyStimulus(1'b1, 16'h0003, 16'h0005, C_MUL, 1'b1);
        stepClock();
        applyStimulus(1'b0, '0, '0, C_ADD, 1'b1);
        repeat (7) stepClock();
        checkOutput("mul_mid.inReady", 32'(inReady), 32'd0);
`else
        applyStimulus(1'b1, 16'hABCD, 16'h0002, C_MUL, 1'b0);
        stepClock();
        checkResult("op10_passA", 16'hABCD, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, C_ADD, 1'b0);
        stepClock();
        checkResult("op10_hold", 16'hABCD, 1'b0, 1'b0);
        outReady = 1'b1;
`endif
        rst = 1'b1;
        #1;
        checkOutput("rst_mid.outValid", 32'(outValid), 32'd0);
        checkOutput("rst_mid.result", 32'(result), 32'h0);
        checkOutput("rst_mid.zero", 32'(zero), 32'd0);
        checkOutput("rst_mid.overflow", 32'(overflow), 32'd0);
        checkOutput("rst_mid.inReady", 32'(inReady), 32'd1);
        stepClock();
        rst = 1'b0;
        #1;
        checkOutput("post_rst.inReady", 32'(inReady), 32'd1);
        checkOutput("post_rst.outValid", 32'(outValid), 32'd0);
        applyStimulus(1'b1, 16'h0002, 16'h0003, C_ADD, 1'b1);
        stepClock();
        checkResult("post_rst_add", 16'h0005, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, C_ADD, 1'b1);
        stepClock();
        checkOutput("final_idle.outValid", 32'(outValid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
